// File: rtl/tdm_pkg.sv
// Shared constants and helpers for the TDM selector path.
package tdm_pkg;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // ceil(log2(n)), never less than 1 so that one-entry ranges still get a bit
  function automatic int safe_clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/tdm_chan_ptr.sv
// Shared channel pointer: manual select or dwell-timed scan, plus frame/sel_err flags.
module tdm_chan_ptr
  import tdm_pkg::*;
#(
  parameter int CH    = 4,
  parameter int DWELL = 1,
  parameter int SELW  = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            mode,
  input  logic [SELW-1:0] sel,
  output logic [SELW-1:0] ptr,
  output logic            frame,
  output logic            sel_err
);

  localparam int              DCW     = safe_clog2(DWELL);
  localparam logic [SELW-1:0] LAST_CH = SELW'(CH - 1);
  localparam logic [DCW-1:0]  LAST_DC = DCW'(DWELL - 1);

  logic [SELW-1:0] ptr_d, ptr_q;
  logic [DCW-1:0]  dcnt_d, dcnt_q;
  logic            frame_d, frame_q;
  logic            sel_err_d, sel_err_q;

  // dcnt rests at 0 in manual mode, so entering scan always starts a full dwell
  always_comb begin
    ptr_d     = ptr_q;
    dcnt_d    = '0;
    frame_d   = 1'b0;
    sel_err_d = 1'b0;
    if (mode == MODE_SCAN) begin
      if (dcnt_q == LAST_DC) begin
        if (ptr_q == LAST_CH) begin
          ptr_d   = '0;
          frame_d = 1'b1;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end else begin
        dcnt_d = dcnt_q + 1'b1;
      end
    end else if (int'(sel) < CH) begin
      ptr_d = sel;
    end else begin
      sel_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q     <= '0;
      dcnt_q    <= '0;
      frame_q   <= 1'b0;
      sel_err_q <= 1'b0;
    end else begin
      ptr_q     <= ptr_d;
      dcnt_q    <= dcnt_d;
      frame_q   <= frame_d;
      sel_err_q <= sel_err_d;
    end
  end

  assign ptr     = ptr_q;
  assign frame   = frame_q;
  assign sel_err = sel_err_q;

endmodule

// File: rtl/tdm_mux_demux.sv
// Registered N-channel mux/demux pair driven by one shared channel pointer.
module tdm_mux_demux
  import tdm_pkg::*;
#(
  parameter int  CH    = 4,
  parameter int  W     = 4,
  parameter int  DWELL = 1,
  localparam int SELW  = safe_clog2(CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mode,
  input  logic [SELW-1:0]   sel,
  input  logic              mux_en,
  input  logic [CH*W-1:0]   mux_in,
  output logic [W-1:0]      mux_out,
  output logic [SELW-1:0]   mux_ch,
  output logic              mux_valid,
  input  logic              demux_en,
  input  logic [W-1:0]      demux_in,
  output logic [CH*W-1:0]   demux_out,
  output logic [CH-1:0]     demux_upd,
  output logic              frame,
  output logic              sel_err
);

  logic [SELW-1:0] ptr;

  tdm_chan_ptr #(.CH(CH), .DWELL(DWELL), .SELW(SELW)) u_ptr (
    .clk     (clk),
    .rst_n   (rst_n),
    .mode    (mode),
    .sel     (sel),
    .ptr     (ptr),
    .frame   (frame),
    .sel_err (sel_err)
  );

  logic [CH-1:0][W-1:0] mux_arr;
  assign mux_arr = mux_in;

  logic [W-1:0]         mux_out_d, mux_out_q;
  logic [SELW-1:0]      mux_ch_d, mux_ch_q;
  logic                 mux_valid_d, mux_valid_q;
  logic [CH-1:0][W-1:0] dem_d, dem_q;
  logic [CH-1:0]        upd_d, upd_q;

  // both sides act on the pointer value from before this edge
  always_comb begin
    mux_out_d   = mux_out_q;
    mux_ch_d    = mux_ch_q;
    mux_valid_d = mux_en;
    if (mux_en) begin
      mux_out_d = mux_arr[ptr];
      mux_ch_d  = ptr;
    end
    for (int c = 0; c < CH; c++) begin
      upd_d[c] = demux_en && (ptr == SELW'(c));
      dem_d[c] = upd_d[c] ? demux_in : dem_q[c];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mux_out_q   <= '0;
      mux_ch_q    <= '0;
      mux_valid_q <= 1'b0;
      dem_q       <= '0;
      upd_q       <= '0;
    end else begin
      mux_out_q   <= mux_out_d;
      mux_ch_q    <= mux_ch_d;
      mux_valid_q <= mux_valid_d;
      dem_q       <= dem_d;
      upd_q       <= upd_d;
    end
  end

  assign mux_out   = mux_out_q;
  assign mux_ch    = mux_ch_q;
  assign mux_valid = mux_valid_q;
  assign demux_out = dem_q;
  assign demux_upd = upd_q;

endmodule

// File: tb/tb_tdm_mux_demux.sv
// Directed bench for tdm_mux_demux: reference model plus literal checkpoints.
module tb_tdm_mux_demux;

  localparam int CH = 4;
  localparam int W = 4;
  localparam int DWELL = 2;

  logic clk, rst_n;
  logic mode, mux_en, demux_en;
  logic [1:0] sel;
  logic [15:0] mux_in;
  logic [3:0] demux_in;
  logic [3:0] mux_out;
  logic [1:0] mux_ch;
  logic mux_valid;
  logic [15:0] demux_out;
  logic [3:0] demux_upd;
  logic frame, sel_err;

  // three-channel instance for the non-power-of-two range checks
  logic mode3;
  logic [1:0] sel3;
  logic [11:0] mux_in3;
  logic [3:0] mux_out3;
  logic [1:0] mux_ch3;
  logic mux_valid3;
  logic [11:0] demux_out3;
  logic [2:0] demux_upd3;
  logic frame3, sel_err3;

  tdm_mux_demux #(.CH(CH), .W(W), .DWELL(DWELL)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
    .mux_en(mux_en), .mux_in(mux_in), .mux_out(mux_out), .mux_ch(mux_ch),
    .mux_valid(mux_valid), .demux_en(demux_en), .demux_in(demux_in),
    .demux_out(demux_out), .demux_upd(demux_upd), .frame(frame), .sel_err(sel_err)
  );

  tdm_mux_demux #(.CH(3), .W(4), .DWELL(2)) dut3 (
    .clk(clk), .rst_n(rst_n), .mode(mode3), .sel(sel3),
    .mux_en(1'b1), .mux_in(mux_in3), .mux_out(mux_out3), .mux_ch(mux_ch3),
    .mux_valid(mux_valid3), .demux_en(1'b0), .demux_in(4'h0),
    .demux_out(demux_out3), .demux_upd(demux_upd3), .frame(frame3), .sel_err(sel_err3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail = 0;
  logic chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: in scan mode the channel is base + (scan edges / DWELL) mod CH,
  // where base is the channel held when scanning began.
  int m_ptr = 0;
  int m_base = 0;
  int m_n = 0;
  logic [3:0] e_mout = '0;
  logic [1:0] e_mch = '0;
  logic e_vld = 1'b0, e_frame = 1'b0, e_err = 1'b0;
  logic [15:0] e_dem = '0;
  logic [3:0] e_upd = '0;

  function automatic int scan_ptr(input int base, input int n);
    return (base + n / DWELL) % CH;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ptr <= 0; m_base <= 0; m_n <= 0;
      e_mout <= '0; e_mch <= '0; e_vld <= 1'b0;
      e_dem <= '0; e_upd <= '0; e_frame <= 1'b0; e_err <= 1'b0;
    end else begin
      if (mux_en) begin
        e_mout <= mux_in[m_ptr*W +: W];
        e_mch  <= 2'(m_ptr);
      end
      e_vld <= mux_en;
      if (demux_en) e_dem[m_ptr*W +: W] <= demux_in;
      e_upd <= demux_en ? 4'(1 << m_ptr) : 4'h0;
      if (mode) begin
        m_n     <= m_n + 1;
        m_ptr   <= scan_ptr(m_base, m_n + 1);
        e_frame <= ((m_n + 1) % DWELL == 0) && (scan_ptr(m_base, m_n + 1) == 0);
        e_err   <= 1'b0;
      end else begin
        m_n     <= 0;
        e_frame <= 1'b0;
        if (int'(sel) < CH) begin
          m_ptr  <= int'(sel);
          m_base <= int'(sel);
          e_err  <= 1'b0;
        end else begin
          m_base <= m_ptr;
          e_err  <= 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("mux_out", 32'(mux_out), 32'(e_mout));
      chk("mux_ch", 32'(mux_ch), 32'(e_mch));
      chk("mux_valid", 32'(mux_valid), 32'(e_vld));
      chk("demux_out", 32'(demux_out), 32'(e_dem));
      chk("demux_upd", 32'(demux_upd), 32'(e_upd));
      chk("frame", 32'(frame), 32'(e_frame));
      chk("sel_err", 32'(sel_err), 32'(e_err));
      chk("ch3_range", 32'(mux_ch3 < 2'd3), 32'd1);
    end
  end

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_mux_out"}, 32'(mux_out), 32'd0);
    chk({tag, "_mux_ch"}, 32'(mux_ch), 32'd0);
    chk({tag, "_mux_valid"}, 32'(mux_valid), 32'd0);
    chk({tag, "_demux_out"}, 32'(demux_out), 32'd0);
    chk({tag, "_demux_upd"}, 32'(demux_upd), 32'd0);
    chk({tag, "_frame"}, 32'(frame), 32'd0);
    chk({tag, "_sel_err"}, 32'(sel_err), 32'd0);
  endtask

  int exp_seq[10] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
  int got_seq[10];
  int frames;
  int frame_idx;

  initial begin
    rst_n = 1'b1; mode = 1'b0; sel = 2'd0; mux_en = 1'b0; mux_in = '0;
    demux_en = 1'b0; demux_in = '0;
    mode3 = 1'b0; sel3 = 2'd0; mux_in3 = 12'h321;
    #1 rst_n = 1'b0;
    #2 chk_zero("rst0");
    step(2);
    rst_n = 1'b1;
    chk_en = 1'b1;

    // manual mux: first edge uses channel 0, then channel 2
    mux_in = 16'hDCBA; sel = 2'd2; mux_en = 1'b1;
    step();
    chk("first_edge_mux_out", 32'(mux_out), 32'hA);
    step();
    chk("man_mux_out", 32'(mux_out), 32'hC);
    chk("man_mux_ch", 32'(mux_ch), 32'd2);
    chk("man_mux_valid", 32'(mux_valid), 32'd1);
    mux_en = 1'b0;
    step();
    chk("mux_off_valid", 32'(mux_valid), 32'd0);
    chk("mux_off_hold", 32'(mux_out), 32'hC);

    // demux hold registers
    sel = 2'd1;
    step();
    demux_en = 1'b1; demux_in = 4'h5; sel = 2'd3;
    step();
    chk("dmx_upd1", 32'(demux_upd), 32'b0010);
    demux_in = 4'h9;
    step();
    chk("dmx_upd3", 32'(demux_upd), 32'b1000);
    chk("dmx_out", 32'(demux_out), 32'h9050);
    demux_en = 1'b0;
    step();
    chk("dmx_upd_off", 32'(demux_upd), 32'd0);
    chk("dmx_hold", 32'(demux_out), 32'h9050);

    // CH=3 out-of-range select
    sel3 = 2'd1;
    step();
    sel3 = 2'd3;
    step();
    chk("ch3_err_set", 32'(sel_err3), 32'd1);
    chk("ch3_ch_hold", 32'(mux_ch3), 32'd1);
    sel3 = 2'd1;
    step();
    chk("ch3_err_clr", 32'(sel_err3), 32'd0);
    chk("ch3_ch", 32'(mux_ch3), 32'd1);
    chk("ch3_out", 32'(mux_out3), 32'h2);
    mode3 = 1'b1;

    // scan from channel 0
    sel = 2'd0;
    step();
    mode = 1'b1; mux_en = 1'b1;
    frames = 0; frame_idx = -1;
    for (int i = 0; i < 10; i++) begin
      step();
      got_seq[i] = int'(mux_ch);
      if (frame) begin
        frames++;
        frame_idx = i;
      end
    end
    for (int i = 0; i < 10; i++) chk($sformatf("scan_seq%0d", i), 32'(got_seq[i]), 32'(exp_seq[i]));
    chk("scan_frames", 32'(frames), 32'd1);
    chk("scan_frame_idx", 32'(frame_idx), 32'd7);

    // mode switch scan -> manual -> scan
    step(2);
    mode = 1'b0; sel = 2'd0;
    step();
    chk("sw_from_ch2", 32'(mux_ch), 32'd2);
    mode = 1'b1;
    step();
    chk("sw_dwell_a", 32'(mux_ch), 32'd0);
    step();
    chk("sw_dwell_b", 32'(mux_ch), 32'd0);
    step();
    chk("sw_adv", 32'(mux_ch), 32'd1);

    // reset mid-scan takes effect without a clock edge
    #1 rst_n = 1'b0;
    #1 chk_zero("rst_mid");
    step();
    rst_n = 1'b1;
    step();
    chk("rst_scan_a", 32'(mux_ch), 32'd0);
    chk("rst_no_frame", 32'(frame), 32'd0);
    step();
    chk("rst_scan_b", 32'(mux_ch), 32'd0);
    step();
    chk("rst_scan_c", 32'(mux_ch), 32'd1);
    step(4);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tdm_mux_demux.md
# tdm_mux_demux

Parametrised, registered N-channel multiplexer/demultiplexer pair sharing one channel pointer, for the board-level selector path. Channels are chosen manually from a select input or by an internal scan counter with programmable dwell (time-division mode). The mux side emits the selected channel's word tagged with its channel number. The demux side writes its input into a per-channel hold register; unselected channels keep their value instead of being zeroed.

## Interface
- CH, 4: channel count, ≥2.
- W, 4: data width per channel, ≥1.
- DWELL, 1: cycles spent on each channel in scan mode, ≥1.
- SELW, derived: max(1, clog2(CH)); not user-overridable.
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- mode  in  1  0 = manual (pointer follows sel), 1 = scan (pointer auto-advances).
- sel  in  SELW  manual channel select.
- mux_en  in  1  mux enable.
- mux_in  in  CH*W  channel c occupies bits [c*W +: W].
- mux_out  out  W  registered selected word.
- mux_ch  out  SELW  channel that produced mux_out.
- mux_valid  out  1  high for one cycle per captured word.
- demux_en  in  1  demux enable.
- demux_in  in  W  word to route.
- demux_out  out  CH*W  per-channel hold registers, same packing as mux_in.
- demux_upd  out  CH  one-hot strobe: channel written on the previous edge.
- frame  out  1  one-cycle pulse when the scan pointer wraps CH-1 -> 0.
- sel_err  out  1  registered flag: sel ≥ CH seen in manual mode on the previous edge.

## Operation
- Pointer ptr (SELW bits) and dwell counter dcnt (0..DWELL-1) are the only control state.
- Manual mode: on each edge ptr <= sel if sel < CH. Otherwise ptr holds and sel_err <= 1. sel_err <= 0 on any other edge. dcnt held at 0.
- Scan mode: dcnt increments each edge. When dcnt == DWELL-1: dcnt <= 0 and ptr <= (ptr == CH-1) ? 0 : ptr+1. frame <= 1 on that wrap edge only. sel is ignored and sel_err <= 0.
- Mode switch manual -> scan: dcnt <= 0 and ptr holds, so scanning starts from the current channel with a full dwell. Scan -> manual: ptr <= sel on the same edge (range rule applies).
- Mux: if mux_en, then mux_out <= mux_in[ptr], mux_ch <= ptr, mux_valid <= 1. Else mux_valid <= 0 and mux_out/mux_ch hold.
- Demux: if demux_en, then demux_out[ptr] <= demux_in and demux_upd <= onehot(ptr). Else demux_upd <= 0. Other channels always hold.
- Both sides use the ptr value present before the edge. A new sel therefore affects data one cycle after it is sampled.
- mux_en and demux_en are independent; both may be active in the same cycle on the same channel.

## Timing
- Reset (rst_n low, immediate): ptr, dcnt, mux_out, mux_ch, mux_valid, demux_out, demux_upd, frame and sel_err all 0.
- First edge after rst_n rises behaves as a normal cycle with ptr = 0.
- Data latency: 1 cycle from mux_in/demux_in sampling to mux_out/demux_out.
- Select latency: sel sampled at edge k; data of that channel appears at edge k+1.
- Scan period: CH*DWELL cycles per frame. frame is asserted once per period, in the cycle after ptr becomes 0.
- Reset mid-scan: the pointer restarts at channel 0 with a full dwell. No frame pulse is generated by reset.
- CH not a power of two: ptr must never take values ≥ CH in either mode.

## Structure
- Shared package tdm_pkg: MODE_MANUAL/MODE_SCAN constants and a safe clog2 function (returns ≥1).
- One sub-module, tdm_chan_ptr: owns ptr, dcnt, frame and sel_err, and exports ptr.
- The top holds the mux and demux datapath registers only.

## Test plan
All scenarios use CH=4, W=4, DWELL=2.
- Reset: drive rst_n low mid-cycle -> all outputs 0 immediately, without waiting for a clock edge.
- Manual mux: mux_in = 0xDCBA, sel = 2, mux_en = 1 -> next cycle mux_out = 0xC, mux_ch = 2, mux_valid = 1. With mux_en = 0 -> mux_valid = 0 and mux_out stays 0xC.
- Manual demux hold: demux_en = 1, sel = 1, demux_in = 0x5, then sel = 3, demux_in = 0x9 -> demux_out = 0x9050, with demux_upd 0010 then 1000. Channels 0 and 2 stay 0.
- Scan: mode = 1 from ptr = 0, mux_en = 1 for 10 cycles -> mux_ch sequence 0,0,1,1,2,2,3,3,0,0. frame pulses exactly once, after the 3 -> 0 wrap.
- Out-of-range select: build with CH=3, manual mode, sel = 1 then sel = 3 -> ptr stays 1, sel_err = 1 for one cycle, and mux_ch never shows 3.
- Mode switch: scanning at ptr = 2, set mode = 0 with sel = 0 -> ptr = 0 on the next edge. Return to mode = 1 -> ptr dwells 2 cycles on 0 before advancing to 1.
